// File: rtl/sdram_seq.sv
`default_nettype none
// ============================================================================
// Module   : sdram_seq
// Brief    : SDRAM command sequencer: power-up init, run-time burst lengths
//            with BST termination, and postponable distributed refresh.
// Revision : 1.0 - initial release
// ============================================================================
module sdram_seq #(
   parameter int T_INIT       = 20000,
   parameter int T_RP         = 4,
   parameter int T_RFC        = 6,
   parameter int T_MRD        = 6,
   parameter int T_RCD        = 2,
   parameter int CAS_LAT      = 3,
   parameter int T_WR         = 3,
   parameter int REF_INTERVAL = 750,
   parameter int REF_MAX      = 8,
   parameter int LEN_W        = 9
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           wr_req,
   input  logic                           rd_req,
   input  logic [LEN_W-1:0]               wr_len,
   input  logic [LEN_W-1:0]               rd_len,
   output logic                           req_taken,
   output logic                           wr_ack,
   output logic                           rd_ack,
   output logic [2:0]                     cmd,
   output logic                           init_done,
   output logic                           busy,
   output logic [$clog2(REF_MAX+1)-1:0]   ref_debt,
   output logic                           ref_err
);

   localparam logic [2:0] c_CMD_NOP   = 3'd0;
   localparam logic [2:0] c_CMD_ACT   = 3'd1;
   localparam logic [2:0] c_CMD_READ  = 3'd2;
   localparam logic [2:0] c_CMD_WRITE = 3'd3;
   localparam logic [2:0] c_CMD_BST   = 3'd4;
   localparam logic [2:0] c_CMD_PRE   = 3'd5;
   localparam logic [2:0] c_CMD_REF   = 3'd6;
   localparam logic [2:0] c_CMD_MRS   = 3'd7;

   function automatic int f_max(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   localparam int c_CNT_MAX = f_max(f_max(f_max(T_INIT, CAS_LAT + (1 << LEN_W)),
                                          f_max(T_RP, T_RFC)),
                                    f_max(f_max(T_MRD, T_RCD), T_WR));
   localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);
   localparam int c_TMR_W   = $clog2(REF_INTERVAL + 1);

   typedef enum logic [4:0] {
      S_IWAIT, S_IPRE, S_ITRP, S_IREF1, S_ITRF1, S_IREF2, S_ITRF2, S_IMRS, S_ITMRD,
      S_IDLE, S_ACT, S_TRCD, S_RD, S_RDAT, S_WR, S_WDAT, S_TWR, S_PRE, S_TRP,
      S_REF, S_TRFC
   } state_t;

   state_t               r_state, w_state_nx;
   logic [c_CNT_W-1:0]   r_cnt;
   logic [LEN_W-1:0]     r_len, w_len_nx;
   logic                 r_is_wr, w_is_wr_nx;
   logic [c_TMR_W-1:0]   r_tmr;
   logic                 w_wrap, w_ref_issue;
   int                   w_cnt, w_cnt_nx, w_len_r, w_debt;
   logic [2:0]           w_cmd_nx;
   logic                 w_rd_ack_nx, w_wr_ack_nx;

   assign w_cnt   = int'(r_cnt);
   assign w_len_r = int'(r_len);
   assign w_debt  = int'(ref_debt);
   assign w_wrap  = init_done && (int'(r_tmr) == REF_INTERVAL - 1);

   // Wait states exit at param-2 because the command state itself is the first
   // cycle of the interval; a param of 1 skips the wait state entirely.
   always_comb begin
      w_state_nx  = r_state;
      w_len_nx    = r_len;
      w_is_wr_nx  = r_is_wr;
      w_ref_issue = 1'b0;
      case (r_state)
         S_IWAIT:  if (w_cnt == T_INIT - 1) w_state_nx = S_IPRE;
         S_IPRE:   w_state_nx = (T_RP == 1) ? S_IREF1 : S_ITRP;
         S_ITRP:   if (w_cnt == T_RP - 2) w_state_nx = S_IREF1;
         S_IREF1:  w_state_nx = (T_RFC == 1) ? S_IREF2 : S_ITRF1;
         S_ITRF1:  if (w_cnt == T_RFC - 2) w_state_nx = S_IREF2;
         S_IREF2:  w_state_nx = (T_RFC == 1) ? S_IMRS : S_ITRF2;
         S_ITRF2:  if (w_cnt == T_RFC - 2) w_state_nx = S_IMRS;
         S_IMRS:   w_state_nx = (T_MRD == 1) ? S_IDLE : S_ITMRD;
         S_ITMRD:  if (w_cnt == T_MRD - 2) w_state_nx = S_IDLE;
         S_IDLE: begin
            if (w_debt == REF_MAX) begin
               w_state_nx  = S_REF;
               w_ref_issue = 1'b1;
            end else if (wr_req) begin
               w_state_nx = S_ACT;
               w_is_wr_nx = 1'b1;
               w_len_nx   = (wr_len == '0) ? LEN_W'(1) : wr_len;
            end else if (rd_req) begin
               w_state_nx = S_ACT;
               w_is_wr_nx = 1'b0;
               w_len_nx   = (rd_len == '0) ? LEN_W'(1) : rd_len;
            end else if (w_debt > 0) begin
               w_state_nx  = S_REF;
               w_ref_issue = 1'b1;
            end
         end
         S_ACT:    w_state_nx = (T_RCD == 1) ? (r_is_wr ? S_WR : S_RD) : S_TRCD;
         S_TRCD:   if (w_cnt == T_RCD - 2) w_state_nx = r_is_wr ? S_WR : S_RD;
         S_RD:     w_state_nx = S_RDAT;
         S_RDAT:   if (w_cnt == CAS_LAT + w_len_r - 2) w_state_nx = S_PRE;
         S_WR:     w_state_nx = S_WDAT;
         S_WDAT:   if (w_cnt == w_len_r - 1) w_state_nx = (T_WR == 1) ? S_PRE : S_TWR;
         S_TWR:    if (w_cnt == T_WR - 2) w_state_nx = S_PRE;
         S_PRE:    w_state_nx = (T_RP == 1) ? S_IDLE : S_TRP;
         S_TRP:    if (w_cnt == T_RP - 2) w_state_nx = S_IDLE;
         S_REF:    w_state_nx = (T_RFC == 1) ? S_IDLE : S_TRFC;
         S_TRFC:   if (w_cnt == T_RFC - 2) w_state_nx = S_IDLE;
         default:  w_state_nx = S_IWAIT;
      endcase
   end

   // Outputs are decoded from the next state/count so they register in step with it.
   always_comb begin
      w_cnt_nx    = (w_state_nx != r_state) ? 0 : w_cnt + 1;
      w_cmd_nx    = c_CMD_NOP;
      w_rd_ack_nx = 1'b0;
      w_wr_ack_nx = 1'b0;
      case (w_state_nx)
         S_IPRE, S_PRE:          w_cmd_nx = c_CMD_PRE;
         S_IREF1, S_IREF2, S_REF: w_cmd_nx = c_CMD_REF;
         S_IMRS:                 w_cmd_nx = c_CMD_MRS;
         S_ACT:                  w_cmd_nx = c_CMD_ACT;
         S_RD:                   w_cmd_nx = c_CMD_READ;
         S_WR: begin
            w_cmd_nx    = c_CMD_WRITE;
            w_wr_ack_nx = 1'b1;
         end
         S_RDAT: begin
            if (w_cnt_nx == w_len_r - 1) w_cmd_nx = c_CMD_BST;
            w_rd_ack_nx = (w_cnt_nx >= CAS_LAT - 1) && (w_cnt_nx <= CAS_LAT + w_len_r - 2);
         end
         S_WDAT: begin
            if (w_cnt_nx == w_len_r - 1) w_cmd_nx = c_CMD_BST;
            w_wr_ack_nx = (w_cnt_nx < w_len_r - 1);
         end
         default: w_cmd_nx = c_CMD_NOP;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= S_IWAIT;
         r_cnt     <= '0;
         r_len     <= '0;
         r_is_wr   <= 1'b0;
         cmd       <= c_CMD_NOP;
         req_taken <= 1'b0;
         wr_ack    <= 1'b0;
         rd_ack    <= 1'b0;
         init_done <= 1'b0;
         busy      <= 1'b1;
      end else begin
         r_state   <= w_state_nx;
         r_cnt     <= w_cnt_nx[c_CNT_W-1:0];
         r_len     <= w_len_nx;
         r_is_wr   <= w_is_wr_nx;
         cmd       <= w_cmd_nx;
         req_taken <= (w_state_nx == S_ACT);
         wr_ack    <= w_wr_ack_nx;
         rd_ack    <= w_rd_ack_nx;
         init_done <= init_done | (w_state_nx == S_IDLE);
         busy      <= (w_state_nx != S_IDLE);
      end
   end

   // A coincident wrap and REF issue cancel; a wrap at saturation is lost.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_tmr    <= '0;
         ref_debt <= '0;
         ref_err  <= 1'b0;
      end else begin
         if (!init_done || w_wrap) r_tmr <= '0;
         else                      r_tmr <= r_tmr + 1'b1;
         if (w_wrap && !w_ref_issue) begin
            if (w_debt == REF_MAX) ref_err  <= 1'b1;
            else                   ref_debt <= ref_debt + 1'b1;
         end else if (!w_wrap && w_ref_issue) begin
            ref_debt <= ref_debt - 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_sdram_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_sdram_seq
// Brief    : Directed scoreboard bench for sdram_seq (default and fast-refresh).
// Revision : 1.0 - initial release
// ============================================================================
module tb_sdram_seq;

   localparam int T_RP = 4, T_RFC = 6, T_MRD = 6, T_RCD = 2, CAS = 3, T_WR = 3;
   localparam int REF_IV = 750, REF_MAX = 8, INIT_RISE = 20022;
   localparam int S_T_INIT = 50;
   localparam logic [2:0] NOP = 3'd0, ACT = 3'd1, RD = 3'd2, WR = 3'd3, BST = 3'd4,
                          PRE = 3'd5, REF = 3'd6, MRS = 3'd7;

   typedef struct packed {
      logic [2:0] cmd;
      logic       rt;
      logic       wa;
      logic       ra;
      logic       busy;
   } obs_t;

   typedef struct {
      int         cyc;
      logic [2:0] cmd;
   } ev_t;

   logic       clk = 1'b0;
   logic       rst_n, rst_n_s;
   logic       wr_req, rd_req, wr_req_s, rd_req_s;
   logic [8:0] wr_len, rd_len, wr_len_s, rd_len_s;
   logic       req_taken, wr_ack, rd_ack, init_done, busy, ref_err;
   logic       req_taken_s, wr_ack_s, rd_ack_s, init_done_s, busy_s, ref_err_s;
   logic [2:0] cmd, cmd_s;
   logic [3:0] ref_debt, ref_debt_s;

   int   n_assert = 0;
   int   n_fail   = 0;
   int   gcyc     = 0;
   obs_t exp_q[$];
   ev_t  ev_q[$];

   always #5 clk = ~clk;

   sdram_seq dut (
      .clk(clk), .rst_n(rst_n), .wr_req(wr_req), .rd_req(rd_req),
      .wr_len(wr_len), .rd_len(rd_len), .req_taken(req_taken), .wr_ack(wr_ack),
      .rd_ack(rd_ack), .cmd(cmd), .init_done(init_done), .busy(busy),
      .ref_debt(ref_debt), .ref_err(ref_err)
   );

   sdram_seq #(.T_INIT(S_T_INIT), .REF_INTERVAL(10)) dut_s (
      .clk(clk), .rst_n(rst_n_s), .wr_req(wr_req_s), .rd_req(rd_req_s),
      .wr_len(wr_len_s), .rd_len(rd_len_s), .req_taken(req_taken_s), .wr_ack(wr_ack_s),
      .rd_ack(rd_ack_s), .cmd(cmd_s), .init_done(init_done_s), .busy(busy_s),
      .ref_debt(ref_debt_s), .ref_err(ref_err_s)
   );

   task automatic step();
      @(posedge clk);
      #1;
      gcyc++;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Expected per-cycle trace of one burst, cycle 0 (the accepting idle cycle) first.
   task automatic push_burst(input bit is_wr, input int len);
      int n, s, bst, pre, last;
      obs_t e;
      n    = (len == 0) ? 1 : len;
      s    = 1 + T_RCD;
      bst  = s + n;
      pre  = is_wr ? bst + T_WR : s + CAS + n;
      last = pre + T_RP - 1;
      e = '0;
      exp_q.push_back(e);
      for (int c = 1; c <= last; c++) begin
         e      = '0;
         e.busy = 1'b1;
         if (c == 1) begin
            e.cmd = ACT;
            e.rt  = 1'b1;
         end else if (c == s)   e.cmd = is_wr ? WR : RD;
         else if (c == bst)     e.cmd = BST;
         else if (c == pre)     e.cmd = PRE;
         if (is_wr && c >= s && c <= s + n - 1)             e.wa = 1'b1;
         if (!is_wr && c >= s + CAS && c <= s + CAS + n - 1) e.ra = 1'b1;
         exp_q.push_back(e);
      end
   endtask

   task automatic check_trace(input string tag);
      obs_t got, exp;
      int   idx;
      idx = 0;
      while (exp_q.size() > 0) begin
         exp = exp_q.pop_front();
         got = {cmd, req_taken, wr_ack, rd_ack, busy};
         chk($sformatf("%s[%0d] {cmd,rt,wa,ra,busy}", tag, idx), 32'(got), 32'(exp));
         if (req_taken) begin
            if (wr_req) wr_req = 1'b0;
            else        rd_req = 1'b0;
         end
         step();
         idx++;
      end
   endtask

   task automatic wait_quiet();
      int k;
      k = 0;
      while (!(busy === 1'b0 && ref_debt === 4'd0) && k < 1000) begin
         step();
         k++;
      end
      chk("quiet-idle-timeout", 32'(k < 1000), 32'd1);
   endtask

   initial begin
      int   rise, first_cyc, ref_cyc, base, exp_dbt, wraps, k;
      bit   ack_early, found, err_drop;
      logic [2:0] first_cmd;
      logic [3:0] prev_debt;
      ev_t  ev;

      rst_n = 1'b0; rst_n_s = 1'b0;
      wr_req = 1'b0; rd_req = 1'b0; wr_len = '0; rd_len = '0;
      wr_req_s = 1'b0; rd_req_s = 1'b0; wr_len_s = '0; rd_len_s = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst cmd", 32'(cmd), 32'(NOP));
      chk("rst req_taken", 32'(req_taken), 32'd0);
      chk("rst acks", 32'({wr_ack, rd_ack}), 32'd0);
      chk("rst init_done", 32'(init_done), 32'd0);
      chk("rst busy", 32'(busy), 32'd1);
      chk("rst ref_debt", 32'(ref_debt), 32'd0);
      chk("rst ref_err", 32'(ref_err), 32'd0);

      // Power-up sequence
      @(negedge clk);
      rst_n = 1'b1; rst_n_s = 1'b1;
      gcyc = 0;
      ev_q.push_back('{20000, PRE});
      ev_q.push_back('{20004, REF});
      ev_q.push_back('{20010, REF});
      ev_q.push_back('{20016, MRS});
      rise = -1; ack_early = 1'b0;
      for (int i = 1; i <= 20030; i++) begin
         step();
         if (cmd !== NOP) begin
            if (ev_q.size() > 0) ev = ev_q.pop_front();
            else                 ev = '{-1, NOP};
            chk($sformatf("init cmd %0d at cycle %0d", cmd, gcyc),
                32'({gcyc[28:0], cmd}), 32'({ev.cyc[28:0], ev.cmd}));
         end
         if (rise < 0 && init_done === 1'b1) rise = gcyc;
         if (rise < 0 && (wr_ack || rd_ack)) ack_early = 1'b1;
      end
      chk("init events left", 32'(ev_q.size()), 32'd0);
      chk("init_done rise cycle", 32'(rise), 32'(INIT_RISE));
      chk("ack before init", 32'(ack_early), 32'd0);
      chk("fast dut init_done", 32'(init_done_s), 32'd1);
      chk("fast dut ref_err at init", 32'(ref_err_s), 32'd0);
      rd_len_s = 9'd255;
      rd_req_s = 1'b1;

      // Directed bursts
      wait_quiet(); rd_len = 9'd4; rd_req = 1'b1; push_burst(1'b0, 4); check_trace("rd4");
      wait_quiet(); wr_len = 9'd1; wr_req = 1'b1; push_burst(1'b1, 1); check_trace("wr1");
      wait_quiet(); wr_len = 9'd0; wr_req = 1'b1; push_burst(1'b1, 0); check_trace("wr0");
      wait_quiet(); wr_len = 9'd3; wr_req = 1'b1; push_burst(1'b1, 3); check_trace("wr3");
      wait_quiet(); rd_len = 9'd0; rd_req = 1'b1; push_burst(1'b0, 0); check_trace("rd0");
      wait_quiet();
      wr_len = 9'd2; rd_len = 9'd1; wr_req = 1'b1; rd_req = 1'b1;
      push_burst(1'b1, 2); push_burst(1'b0, 1); check_trace("wr+rd");

      // Refresh postponement under back-to-back reads
      wait_quiet();
      rd_len = 9'd255; rd_req = 1'b1;
      found = 1'b0; ref_cyc = 0; prev_debt = '0;
      for (int i = 0; i < 9000 && !found; i++) begin
         prev_debt = ref_debt;
         step();
         if (cmd === REF) begin
            found   = 1'b1;
            ref_cyc = gcyc;
         end
      end
      chk("forced REF seen", 32'(found), 32'd1);
      chk("debt before forced REF", 32'(prev_debt), 32'(REF_MAX));
      exp_dbt = REF_MAX - 1 + ((((ref_cyc - INIT_RISE) % REF_IV) == 0) ? 1 : 0);
      chk("debt at forced REF", 32'(ref_debt), 32'(exp_dbt));
      chk("ref_err after postponement", 32'(ref_err), 32'd0);
      wraps = 0;
      for (int c = ref_cyc + 1; c <= ref_cyc + T_RFC; c++)
         if (((c - INIT_RISE) % REF_IV) == 0) wraps++;
      repeat (T_RFC) step();
      chk("idle after forced REF", 32'(busy), 32'd0);
      step();
      chk("cmd after forced REF", 32'(cmd), 32'((exp_dbt + wraps >= REF_MAX) ? REF : ACT));
      rd_req = 1'b0;
      wait_quiet();

      // Saturation on the fast-refresh instance
      chk("sat ref_err set", 32'(ref_err_s), 32'd1);
      err_drop = 1'b0;
      for (int i = 0; i < 300; i++) begin
         step();
         if (ref_err_s !== 1'b1) err_drop = 1'b1;
      end
      chk("sat ref_err sticky", 32'(err_drop), 32'd0);
      k = 0;
      while (rd_ack_s !== 1'b1 && k < 600) begin
         step();
         k++;
      end
      chk("sat mid-burst reached", 32'(k < 600), 32'd1);
      chk("sat debt mid-burst", 32'(ref_debt_s), 32'(REF_MAX));

      // Asynchronous reset mid-burst
      rst_n_s = 1'b0;
      #1;
      chk("async rst cmd/acks", 32'({cmd_s, req_taken_s, wr_ack_s, rd_ack_s}), 32'd0);
      chk("async rst ref_err", 32'(ref_err_s), 32'd0);
      chk("async rst debt/init/busy", 32'({ref_debt_s, init_done_s, busy_s}), 32'd1);
      rd_req_s = 1'b0;
      @(negedge clk);
      rst_n_s = 1'b1;
      base = gcyc; first_cyc = -1; first_cmd = NOP; rise = -1;
      for (int i = 0; i < 80; i++) begin
         step();
         if (first_cyc < 0 && cmd_s !== NOP) begin
            first_cyc = gcyc - base;
            first_cmd = cmd_s;
         end
         if (rise < 0 && init_done_s === 1'b1) rise = gcyc - base;
      end
      chk("reinit first cmd cycle", 32'(first_cyc), 32'(S_T_INIT));
      chk("reinit first cmd", 32'(first_cmd), 32'(PRE));
      chk("reinit init_done cycle", 32'(rise), 32'(S_T_INIT + T_RP + 2 * T_RFC + T_MRD));

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/sdram_seq.md
# sdram_seq

Parametrised SDRAM command sequencer, the next generation of the SDRAM state controller. It sits between the read/write FIFO arbitration and the SDRAM pin driver. It handles power-up initialisation, bursts with read and write lengths set at run time, burst termination, and distributed refresh with up to REF_MAX postponed refreshes. All device timings are parameters, and it emits one registered command per cycle.

## Interface
- T_INIT, 20000: power-up NOP wait in cycles.
- T_RP, 4: PRECHARGE to next command, in cycles.
- T_RFC, 6: REFRESH to next command, in cycles.
- T_MRD, 6: MRS to next command, in cycles.
- T_RCD, 2: ACTIVE to READ/WRITE, in cycles.
- CAS_LAT, 3: read latency. Legal values are 2 and 3.
- T_WR, 3: cycles from the write-burst BST to PRECHARGE.
- REF_INTERVAL, 750: cycles between refresh credits.
- REF_MAX, 8: maximum number of postponed refreshes.
- LEN_W, 9: width of the burst-length inputs.
- All timing parameters are ≥1.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- wr_req  in  1  write request, level
- rd_req  in  1  read request, level
- wr_len  in  LEN_W  write burst length in words
- rd_len  in  LEN_W  read burst length in words
- req_taken  out  1  one-cycle pulse when a request is accepted
- wr_ack  out  1  write-data strobe; the upstream FIFO word is consumed in this cycle
- rd_ack  out  1  read-data valid
- cmd  out  3  command: 0 NOP, 1 ACT, 2 READ, 3 WRITE, 4 BST, 5 PRE_ALL, 6 REF, 7 MRS
- init_done  out  1  initialisation complete
- busy  out  1  high when not in S_IDLE or when init_done=0
- ref_debt  out  $clog2(REF_MAX+1)  count of pending refreshes
- ref_err  out  1  sticky flag: a refresh credit was lost at saturation

## Operation
- Single FSM.
  - Initialisation states: S_IWAIT, S_IPRE, S_ITRP, S_IREF1, S_ITRF1, S_IREF2, S_ITRF2, S_IMRS, S_ITMRD.
  - Working states: S_IDLE, S_ACT, S_TRCD, S_RD, S_RDAT, S_WR, S_WDAT, S_TWR, S_PRE, S_TRP, S_REF, S_TRFC.
- One shared cycle counter is cleared on every state change. Every wait state exits when the counter reaches (parameter − 1), counted from the command cycle.
- Initialisation sequence:
  - NOP for T_INIT cycles.
  - PRE_ALL, then T_RP.
  - REF, then T_RFC; REF again, then T_RFC.
  - MRS, then T_MRD.
  - Enter S_IDLE and set init_done=1. init_done stays high until reset.
- Refresh timer:
  - Held at 0 while init_done=0.
  - Afterwards it wraps every REF_INTERVAL cycles, and each wrap adds one credit to ref_debt.
  - Issuing REF subtracts one credit.
  - If a wrap and a REF issue fall in the same cycle, ref_debt is unchanged.
  - If a wrap occurs while ref_debt=REF_MAX, ref_debt stays at REF_MAX and ref_err is set.
- S_IDLE arbitration, evaluated each cycle in priority order:
  1. ref_debt=REF_MAX → refresh, even if a request is pending.
  2. wr_req → write.
  3. rd_req → read.
  4. ref_debt>0 → refresh.
  5. Otherwise stay in S_IDLE with cmd=NOP.
- Request capture:
  - Burst length is sampled in the accept cycle; a length of 0 is treated as 1.
  - The requester must drop its request after req_taken. A request still high when the FSM returns to S_IDLE is accepted as a new burst.
- Every access closes the row with PRE_ALL, so refresh never requires a separate precharge.

## Timing
Cycle 0 is the S_IDLE cycle in which the request is accepted. All outputs are registered.
- Read of N words:
  - Cycle 1: req_taken=1, cmd=ACT.
  - Cycle R=1+T_RCD: cmd=READ.
  - Cycle R+N: cmd=BST.
  - Cycles R+CAS_LAT … R+CAS_LAT+N−1: rd_ack=1.
  - Cycle R+CAS_LAT+N: cmd=PRE_ALL.
  - S_IDLE again at PRE+T_RP.
  - If BST falls in the same cycle as… not applicable; BST and PRE never coincide, since N≥1 and CAS_LAT≥2.
- Write of N words:
  - Cycle 1: cmd=ACT.
  - Cycle W=1+T_RCD: cmd=WRITE.
  - Cycles W … W+N−1: wr_ack=1, so the first word travels with the WRITE command.
  - Cycle W+N: cmd=BST.
  - Cycle W+N+T_WR: cmd=PRE_ALL.
  - S_IDLE again at PRE+T_RP.
- Refresh:
  - Cycle 1: cmd=REF.
  - S_IDLE again at cycle 1+T_RFC.
- Every cycle not listed above carries cmd=NOP.
- Reset values: cmd=NOP, req_taken=wr_ack=rd_ack=0, init_done=0, busy=1, ref_debt=0, ref_err=0, state S_IWAIT, all counters 0.
- Reset mid-operation:
  - All outputs clear immediately (asynchronously).
  - Any in-flight burst is abandoned without PRE.
  - Initialisation restarts from S_IWAIT.

## Test plan
- Power-up with default parameters:
  - cmd sequence is PRE_ALL at cycle 20000, REF at 20004, REF at 20010, MRS at 20016.
  - init_done rises at 20022.
  - No wr_ack or rd_ack occurs before then.
- Read, rd_len=4, defaults:
  - ACT at 1, READ at 3, BST at 7.
  - rd_ack high on cycles 6–9.
  - PRE_ALL at 10; next accept possible at 14.
- Write, wr_len=1, then wr_len=0:
  - Each burst gives exactly one wr_ack cycle, coinciding with WRITE.
  - BST follows one cycle later; PRE_ALL comes 3 cycles after BST.
- wr_req and rd_req asserted together:
  - The write is served first; the read is accepted at the next S_IDLE.
  - req_taken pulses once per burst.
- Refresh postponement:
  - Hold rd_req with back-to-back 255-word reads.
  - ref_debt climbs to 8, then REF is forced ahead of the pending read.
  - ref_debt drops to 7, and ref_err stays 0.
- Saturation:
  - With REF_INTERVAL=10 and continuous 255-word reads, ref_err sets and stays set.
  - Asserting rst_n=0 mid-burst forces cmd=NOP and ref_err=0 immediately, and initialisation reruns.
